sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
- Single-clock synchronous FIFO for byte data, with internal storage, read/write pointers, an occupancy counter, and full/empty status flags.
- Sits between a byte producer (drives wr/din) and a byte consumer (drives rd, takes dout).
- Producer must not write when full; consumer must not read when empty. The FIFO also guards both cases internally.
- Internal signals wptr, rptr and cnt are named exactly so; bound checkers probe them hierarchically.

Parameters:
- DATA_W, 8, data width of din/dout.
- DEPTH, 15, usable capacity in entries; storage array has DEPTH words.
- PTR_W, 4, width of wptr/rptr; must satisfy 2**PTR_W >= DEPTH.
- CNT_W, 5, width of cnt; must hold 0..DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- wr  input  1  write request.
- rd  input  1  read request.
- din  input  DATA_W  write data, sampled on clk edge when a write is accepted.
- dout  output  DATA_W  registered read data.
- empty  output  1  high when cnt==0.
- full  output  1  high when cnt==DEPTH.

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high (rst).
- Reset:
  - On a rising edge with rst=1: wptr=0, rptr=0, cnt=0, dout=0.
  - Flags follow immediately: empty=1, full=0, held every cycle while rst is high.
  - rst overrides wr/rd.
  - Reset mid-operation discards all contents; storage array need not be cleared.
- Flags: combinational decode of cnt. full = (cnt==DEPTH), empty = (cnt==0). Never both high.
- Write accept = wr & !rd & !full & !rst. On accept:
  - mem[wptr] <= din.
  - wptr <= (wptr==DEPTH-1) ? 0 : wptr+1.
  - cnt <= cnt+1.
- Read accept = rd & !wr & !empty & !rst. On accept:
  - dout <= mem[rptr]; one-cycle latency, valid the cycle after the rd edge.
  - rptr <= (rptr==DEPTH-1) ? 0 : rptr+1.
  - cnt <= cnt-1.
- Simultaneous wr&rd (not in reset): no operation. Pointers, cnt, mem and dout all hold.
- Write while full: ignored; wptr, cnt and mem unchanged.
- Read while empty: ignored; rptr and cnt unchanged, dout holds its last value.
- Idle (no accept): wptr, rptr, cnt and dout stable.
- Wrap-around:
  - After DEPTH writes from reset, wptr==0 and full=1; wptr stays 0 until full falls.
  - After DEPTH reads from full, rptr==0 and empty=1.
- Ordering: strict first-in first-out; the N-th accepted write is returned by the N-th accepted read.
- No X on outputs after the first reset edge.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- When defined, two extra outputs are added:
  - overflow (1 bit): set on any clk edge with wr=1, rd=0, full=1, not in reset.
  - underflow (1 bit): set on any clk edge with rd=1, wr=0, empty=1, not in reset.
  - Both are sticky until a rst edge clears them to 0.
- When undefined, these ports and their logic are absent and the port list is exactly as above.
- Data-path behaviour is identical in both builds.

Test Plan:
1. rst=1 for 1 cycle with wr/rd in every combination (00, 01, 10, 11) -> next cycle empty=1, full=0, dout=0, wptr=rptr=cnt=0.
2. After reset, 15 consecutive writes of random bytes (rd=0) -> full rises after the 15th edge with cnt=15, wptr=0; empty falls after the 1st write.
3. A 16th write while full -> cnt stays 15, wptr stays 0, contents unchanged (overflow=1 if feature enabled).
4. One cycle of wr=1, rd=1 while holding 15 entries -> wptr, rptr, cnt and dout unchanged.
5. 15 consecutive reads -> dout sequence equals the written bytes in order, each appearing 1 cycle after its rd edge; empty=1 and rptr=0 after the 15th read; full falls after the 1st read.
6. Read while empty -> rptr and cnt stay 0 and dout holds the last byte (underflow=1 if feature enabled); then rst=1 -> underflow/overflow=0, empty=1.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock byte FIFO with internal storage, wrapping read/write pointers,
// an occupancy counter and full/empty flags.
//
// Ports:
//   clk       in   clock; all state updates on the rising edge
//   rst       in   synchronous active-high reset; overrides wr/rd
//   wr        in   write request
//   rd        in   read request
//   din       in   write data, captured when a write is accepted
//   dout      out  registered read data, valid the cycle after an accepted read
//   empty     out  cnt == 0
//   full      out  cnt == DEPTH
//   overflow  out  sticky: write attempted while full   (SYNC_FIFO_ERR_FLAGS_EN only)
//   underflow out  sticky: read attempted while empty   (SYNC_FIFO_ERR_FLAGS_EN only)
//
// Optional build macro: SYNC_FIFO_ERR_FLAGS_EN adds the sticky overflow/underflow outputs.
// The data path is identical in both builds.
//
// Simultaneous wr and rd is treated as a no-op: nothing moves.

module sync_fifo_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 15,
    parameter int unsigned PTR_W  = 4,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    output logic              full,
    output logic              overflow,
    output logic              underflow
`else
    output logic              full
`endif
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [CNT_W-1:0]  cnt;

    logic              wr_accept;
    logic              rd_accept;
    logic [PTR_W-1:0]  wptr_nxt;
    logic [PTR_W-1:0]  rptr_nxt;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

    always_comb begin
        wr_accept = wr & ~rd & ~full  & ~rst;
        rd_accept = rd & ~wr & ~empty & ~rst;
        // Pointers wrap at DEPTH, not at 2**PTR_W, since DEPTH need not be a power of two.
        wptr_nxt  = (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
        rptr_nxt  = (rptr == PTR_W'(DEPTH - 1)) ? '0 : rptr + PTR_W'(1);
    end

    // Storage is not reset; the pointers and count alone define valid contents.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            dout <= '0;
        end else begin
            if (wr_accept) begin
                wptr <= wptr_nxt;
                cnt  <= cnt + CNT_W'(1);
            end else if (rd_accept) begin
                rptr <= rptr_nxt;
                cnt  <= cnt - CNT_W'(1);
                dout <= mem[rptr];
            end
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr && !rd && full) begin
                overflow <= 1'b1;
            end
            if (rd && !wr && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;

    localparam int DEPTH = 15;

    logic       clk;
    logic       rst;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       empty;
    logic       full;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [$];
    logic [7:0] last_byte;
    logic [7:0] exp_byte;

    sync_fifo_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .rd       (rd),
        .din      (din),
        .dout     (dout),
        .empty    (empty),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .full     (full),
        .overflow (overflow),
        .underflow(underflow)
`else
        .full     (full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        wr  = 1'b0;
        rd  = 1'b0;
        din = 8'h00;
        tick();

        // Reset with every wr/rd combination, each time from a non-empty, non-zero-dout state.
        for (int i = 0; i < 4; i++) begin
            rst = 1'b0;
            wr  = 1'b1;
            rd  = 1'b0;
            din = 8'h5A + 8'(i);
            tick();
            din = 8'hC3;
            tick();
            wr = 1'b0;
            rd = 1'b1;
            tick();
            rd = 1'b0;
            chk($sformatf("pre_rst_dout_%0d", i), 32'(dout), 32'(8'h5A + 8'(i)));
            chk($sformatf("pre_rst_cnt_%0d", i), 32'(dut.cnt), 32'd1);
            rst = 1'b1;
            {wr, rd} = 2'(i);
            din = 8'hFF;
            tick();
            chk($sformatf("rst_empty_%0d", i), 32'(empty), 32'd1);
            chk($sformatf("rst_full_%0d", i), 32'(full), 32'd0);
            chk($sformatf("rst_dout_%0d", i), 32'(dout), 32'd0);
            chk($sformatf("rst_wptr_%0d", i), 32'(dut.wptr), 32'd0);
            chk($sformatf("rst_rptr_%0d", i), 32'(dut.rptr), 32'd0);
            chk($sformatf("rst_cnt_%0d", i), 32'(dut.cnt), 32'd0);
        end
        rst = 1'b0;
        wr  = 1'b0;
        rd  = 1'b0;
        tick();

        // Fill with DEPTH random bytes; the scoreboard records each accepted write.
        for (int i = 0; i < DEPTH; i++) begin
            wr  = 1'b1;
            din = 8'($urandom_range(0, 255));
            sb.push_back(din);
            tick();
            chk($sformatf("fill_cnt_%0d", i), 32'(dut.cnt), 32'(i + 1));
            chk($sformatf("fill_empty_%0d", i), 32'(empty), 32'd0);
            chk($sformatf("fill_full_%0d", i), 32'(full), 32'(i == DEPTH - 1));
        end
        chk("fill_wptr_wrap", 32'(dut.wptr), 32'd0);

        // Write while full: must be dropped (not pushed to the scoreboard).
        din = ~sb[0];
        tick();
        chk("ovf_cnt", 32'(dut.cnt), 32'd15);
        chk("ovf_wptr", 32'(dut.wptr), 32'd0);
        chk("ovf_full", 32'(full), 32'd1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("ovf_flag", 32'(overflow), 32'd1);
`endif

        // wr and rd together: nothing moves; dout still holds the reset value.
        rd = 1'b1;
        tick();
        chk("both_wptr", 32'(dut.wptr), 32'd0);
        chk("both_rptr", 32'(dut.rptr), 32'd0);
        chk("both_cnt", 32'(dut.cnt), 32'd15);
        chk("both_dout", 32'(dout), 32'd0);

        // Drain: each read returns the oldest outstanding write one cycle after its edge.
        wr = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rd = 1'b1;
            tick();
            exp_byte = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            last_byte = exp_byte;
            chk($sformatf("drain_dout_%0d", i), 32'(dout), 32'(exp_byte));
            chk($sformatf("drain_cnt_%0d", i), 32'(dut.cnt), 32'(DEPTH - 1 - i));
            chk($sformatf("drain_full_%0d", i), 32'(full), 32'd0);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_rptr_wrap", 32'(dut.rptr), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Read while empty: ignored, dout holds the last byte.
        tick();
        rd = 1'b0;
        chk("udf_rptr", 32'(dut.rptr), 32'd0);
        chk("udf_cnt", 32'(dut.cnt), 32'd0);
        chk("udf_dout", 32'(dout), 32'(last_byte));
        chk("udf_empty", 32'(empty), 32'd1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("udf_flag", 32'(underflow), 32'd1);
        chk("ovf_sticky", 32'(overflow), 32'd1);
`endif

        // Idle cycle: everything stable.
        tick();
        chk("idle_dout", 32'(dout), 32'(last_byte));
        chk("idle_wptr", 32'(dut.wptr), 32'd0);

        // Final reset clears the sticky flags.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("final_empty", 32'(empty), 32'd1);
        chk("final_full", 32'(full), 32'd0);
        chk("final_dout", 32'(dout), 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("final_ovf", 32'(overflow), 32'd0);
        chk("final_udf", 32'(underflow), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
